// File: rtl/dump_pkg.sv
// dump_pkg
// Shared definitions for the memory dump reader: the FSM state encoding,
// fixed framing sizes, and the word-alignment mask applied to the byte
// addresses that come from the write-range tracker.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    READ = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } dump_state_e;

  localparam int          HDR_BYTES       = 8;
  localparam int          BYTES_PER_WORD  = 4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dump_byte_serializer.sv
// dump_byte_serializer
// Loads a 32-bit word and presents it as BYTES_PER_WORD bytes, LSB first,
// on a valid/ready byte interface. The byte on data stays stable until it is
// accepted. A load takes priority over the shift, so the owner can reload on
// the same cycle that the last byte is accepted and keep the stream gap-free.
//
// Ports:
//   clk        system clock
//   srst       synchronous active-high reset (empties the serializer)
//   load       load load_data and start emitting it
//   load_data  word to serialize
//   ready      downstream accepts data when valid && ready
//   data       current byte
//   valid      a byte is pending
//   last       the pending byte is the final byte of the word
module dump_byte_serializer
  import dump_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        last
);

  logic [31:0] shift_reg;
  logic [31:0] shift_down;
  logic [2:0]  cnt_reg;

  // Byte-lane shift toward the LSB; the top lane fills with zero.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi < BYTES_PER_WORD - 1) begin : g_move
        assign shift_down[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
      end else begin : g_fill
        assign shift_down[gi*8 +: 8] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      shift_reg <= 32'h0;
      cnt_reg   <= 3'd0;
    end else if (load) begin
      shift_reg <= load_data;
      cnt_reg   <= 3'(BYTES_PER_WORD);
    end else if (valid && ready) begin
      shift_reg <= shift_down;
      cnt_reg   <= cnt_reg - 3'd1;
    end
  end

  assign data  = shift_reg[7:0];
  assign valid = (cnt_reg != 3'd0);
  assign last  = (cnt_reg == 3'd1);

endmodule

// File: rtl/memory_dump_reader.sv
// memory_dump_reader
// Streams the word range recorded by the write-range tracker out as bytes:
// an 8-byte header (start address, word count, both LSB first) followed by
// every word of the range read through the synchronous memory port and sent
// LSB first.
//
// Ports:
//   clk           system clock
//   soft_reset_i  synchronous active-high reset; aborts a dump in progress
//   start_i       one-cycle dump request, honoured only when idle
//   min_addr_i    lowest written byte address (sampled at start)
//   max_addr_i    highest written byte address (sampled at start)
//   mem_re_o      memory read strobe
//   mem_addr_o    word-aligned read address (0 when not reading)
//   mem_rdata_i   read data, one cycle after mem_re_o
//   tx_data_o     byte to the transmitter
//   tx_valid_o    tx_data_o is valid
//   tx_ready_i    transmitter accepts the byte
//   busy_o        dump in progress
//   done_o        one-cycle pulse at the end of a dump
module memory_dump_reader
  import dump_pkg::*;
(
  input  logic        clk,
  input  logic        soft_reset_i,
  input  logic        start_i,
  input  logic [31:0] min_addr_i,
  input  logic [31:0] max_addr_i,
  output logic        mem_re_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int HDR_FIELDS = HDR_BYTES / BYTES_PER_WORD;

  dump_state_e state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] idx_reg, idx_next;
  logic [1:0]  hdr_field_reg, hdr_field_next;

  logic        ser_load;
  logic [31:0] ser_load_data;
  logic        ser_last;
  logic        byte_done;

  logic [31:0] min_al;
  logic [31:0] max_al;
  logic        no_writes;

  assign min_al    = min_addr_i & ADDR_ALIGN_MASK;
  assign max_al    = max_addr_i & ADDR_ALIGN_MASK;
  // The tracker reports min > max when nothing has been written.
  assign no_writes = (min_addr_i > max_addr_i);

  // Final byte of the word currently held by the serializer is accepted.
  assign byte_done = tx_valid_o && tx_ready_i && ser_last;

  dump_byte_serializer u_ser (
    .clk       (clk),
    .srst      (soft_reset_i),
    .load      (ser_load),
    .load_data (ser_load_data),
    .ready     (tx_ready_i),
    .data      (tx_data_o),
    .valid     (tx_valid_o),
    .last      (ser_last)
  );

  always_ff @(posedge clk) begin
    if (soft_reset_i) begin
      state_reg     <= IDLE;
      addr_reg      <= 32'h0;
      count_reg     <= 32'h0;
      idx_reg       <= 32'h0;
      hdr_field_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      count_reg     <= count_next;
      idx_reg       <= idx_next;
      hdr_field_reg <= hdr_field_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    count_next     = count_reg;
    idx_next       = idx_reg;
    hdr_field_next = hdr_field_reg;
    ser_load       = 1'b0;
    ser_load_data  = 32'h0;
    mem_re_o       = 1'b0;
    mem_addr_o     = 32'h0;
    busy_o         = 1'b0;
    done_o         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next     = HDR;
          idx_next       = 32'h0;
          hdr_field_next = 2'd0;
          ser_load       = 1'b1;
          if (no_writes) begin
            addr_next     = 32'h0;
            count_next    = 32'h0;
            ser_load_data = 32'h0;
          end else begin
            // Range spans at most 2^30 words, so this fits in 32 bits.
            addr_next     = min_al;
            count_next    = ((max_al - min_al) >> 2) + 32'd1;
            ser_load_data = min_al;
          end
        end
      end

      HDR: begin
        busy_o = 1'b1;
        if (byte_done) begin
          if (hdr_field_reg != 2'(HDR_FIELDS - 1)) begin
            // Start field finished: chain the count field with no gap.
            hdr_field_next = hdr_field_reg + 2'd1;
            ser_load       = 1'b1;
            ser_load_data  = count_reg;
          end else if (count_reg == 32'h0) begin
            state_next = DONE;
          end else begin
            state_next = READ;
          end
        end
      end

      READ: begin
        busy_o     = 1'b1;
        mem_re_o   = 1'b1;
        mem_addr_o = addr_reg;
        state_next = WAIT;
      end

      WAIT: begin
        // Read latency is fixed at one cycle, so the data is here now.
        busy_o        = 1'b1;
        ser_load      = 1'b1;
        ser_load_data = mem_rdata_i;
        state_next    = SEND;
      end

      SEND: begin
        busy_o = 1'b1;
        if (byte_done) begin
          idx_next  = idx_reg + 32'd1;
          // Address may wrap after the final word; it is never used then.
          addr_next = addr_reg + 32'd4;
          if (idx_reg + 32'd1 == count_reg) begin
            state_next = DONE;
          end else begin
            state_next = READ;
          end
        end
      end

      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_dump_reader.sv
module tb_memory_dump_reader;

  logic        clk = 1'b0;
  logic        soft_reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] min_addr_i = 32'h0;
  logic [31:0] max_addr_i = 32'h0;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;

  memory_dump_reader dut (
    .clk          (clk),
    .soft_reset_i (soft_reset_i),
    .start_i      (start_i),
    .min_addr_i   (min_addr_i),
    .max_addr_i   (max_addr_i),
    .mem_re_o     (mem_re_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          done_count = 0;
  int          rmode = 0;   // 0: always ready, 1: toggle, 2: random
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: fixed words for the documented scenario, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h1122_3344;
      32'h0000_0014: return 32'h5566_7788;
      32'h0000_0018: return 32'h99AA_BBCC;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  // Synchronous read port with one cycle of latency.
  always @(posedge clk) mem_rdata_i <= mem_re_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: header fields and the byte stream from plain arithmetic.
  task automatic model_push(input logic [31:0] mn, input logic [31:0] mx, output longint cnt);
    longint lo, hi, start_f;
    if (mn > mx) begin
      start_f = 0;
      cnt = 0;
    end else begin
      lo = longint'(mn) - (longint'(mn) % 4);
      hi = longint'(mx) - (longint'(mx) % 4);
      start_f = lo;
      cnt = (hi - lo) / 4 + 1;
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((start_f >> (8 * i)) & 255));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((cnt >> (8 * i)) & 255));
    for (longint k = 0; k < cnt; k++) begin
      logic [31:0] a, w;
      a = 32'(start_f + 4 * k);
      w = mem_word(a);
      addr_q.push_back(a);
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    end
  endtask

  // Ready pattern driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = ~tx_ready_i;
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_data = 8'h0;
  always @(negedge clk) begin
    if (tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) chk("extra_byte", {1'b1, tx_data_o}, 0);
      else                   chk("byte", tx_data_o, exp_q.pop_front());
    end
    if (mem_re_o) begin
      if (addr_q.size() == 0) chk("extra_read", {1'b1, mem_addr_o}, 0);
      else                    chk("read_addr", mem_addr_o, addr_q.pop_front());
    end
    if (done_o) begin
      done_count++;
      chk("done_bytes_left", exp_q.size(), 0);
      chk("done_reads_left", addr_q.size(), 0);
    end
    if (prev_valid && !prev_ready && !prev_rst)
      chk("stall_hold", {tx_valid_o, tx_data_o}, {1'b1, prev_data});
    prev_valid = tx_valid_o;
    prev_ready = tx_ready_i;
    prev_data  = tx_data_o;
    prev_rst   = soft_reset_i;
  end

  task automatic issue_start(input logic [31:0] mn, input logic [31:0] mx, output int unsigned t0);
    @(posedge clk); #1;
    min_addr_i = mn;
    max_addr_i = mx;
    start_i    = 1'b1;
    t0         = cyc;
    @(posedge clk); #1;
    start_i    = 1'b0;
    min_addr_i = $urandom;  // later changes must not matter
    max_addr_i = $urandom;
  endtask

  task automatic run_dump(input logic [31:0] mn, input logic [31:0] mx, input int mode,
                          input bit check_lat, input bit poke);
    longint      cnt;
    int unsigned t0;
    bit          got;
    rmode = mode;
    model_push(mn, mx, cnt);
    issue_start(mn, mx, t0);
    @(negedge clk);
    chk("first_busy_valid", {busy_o, tx_valid_o}, 2'b11);
    if (poke) begin
      @(posedge clk); #1;
      min_addr_i = 32'h0000_0100;
      max_addr_i = 32'h0000_01FF;
      start_i    = 1'b1;
      @(posedge clk); #1;
      start_i    = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    else if (check_lat) chk("done_latency", 64'(cyc - t0), 64'(9 + 6 * cnt));
    @(negedge clk);
    chk("idle_after_done", {busy_o, done_o, tx_valid_o}, 3'b000);
    $display("dump min=%08h max=%08h words=%0d mode=%0d", mn, mx, cnt, mode);
  endtask

  initial begin
    int unsigned t0;
    longint      cnt;
    int          dc;
    logic [31:0] mn, mx;
    int          span;

    repeat (3) @(posedge clk);
    #1 soft_reset_i = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {tx_valid_o, tx_data_o, mem_re_o, mem_addr_o, busy_o, done_o}, 0);

    // Documented scenarios.
    run_dump(32'h0000_0010, 32'h0000_0018, 0, 1'b1, 1'b0);  // normal
    run_dump(32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b1, 1'b0);  // empty range
    run_dump(32'h0000_0022, 32'h0000_0023, 0, 1'b1, 1'b0);  // unaligned single word
    run_dump(32'h0000_0010, 32'h0000_0018, 1, 1'b0, 1'b0);  // backpressure
    run_dump(32'h0000_0010, 32'h0000_0018, 0, 1'b1, 1'b1);  // start while busy
    run_dump(32'hFFFF_FFF0, 32'hFFFF_FFFF, 2, 1'b0, 1'b0);  // top of address space

    // Reset during word 1's SEND.
    rmode = 0;
    model_push(32'h0000_0010, 32'h0000_0018, cnt);
    issue_start(32'h0000_0010, 32'h0000_0018, t0);
    for (int i = 0; i < 100 && cyc < t0 + 18; i++) begin
      @(posedge clk); #1;
    end
    dc = done_count;
    soft_reset_i = 1'b1;
    @(posedge clk); #1;
    soft_reset_i = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {tx_valid_o, tx_data_o, mem_re_o, mem_addr_o, busy_o, done_o}, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_count, dc);
    $display("dump aborted by reset at cycle %0d", cyc);
    run_dump(32'h0000_0010, 32'h0000_0018, 0, 1'b1, 1'b0);

    // Randomized ranges and ready patterns.
    for (int n = 0; n < 14; n++) begin
      mn   = $urandom;
      span = $urandom_range(0, 40);
      if (mn > 32'hFFFF_FFFF - 32'(span)) mn = 32'hFFFF_FFFF - 32'(span);
      mx = mn + 32'(span);
      if ($urandom_range(0, 4) == 0) begin
        mx = mn;
        mn = mx + 32'd1 + 32'($urandom_range(0, 100));
        if (mn <= mx) mn = 32'hFFFF_FFFF;
        if (mn <= mx) mx = 32'h0;
      end
      run_dump(mn, mx, n % 3, (n % 3) == 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
